// File: rtl/wb_check_monitor_if.sv
// Writeback snoop bundle: register-file write port plus the fetch PC of the
// core under test. The core side drives it, the monitor only listens.
interface wb_check_monitor_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32
);
  logic                      wb_en;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [PC_WIDTH-1:0]       pc;

  modport master (output wb_en, wb_addr, wb_data, pc);
  modport slave  (input  wb_en, wb_addr, wb_data, pc);
endinterface

// File: rtl/wb_check_monitor.sv
// Self-checking writeback monitor: shadows the core's register file, detects
// halt (PC self-loop) or a cycle-budget timeout, then walks a loaded table of
// expected register values against the shadow copy, one entry per cycle.
module wb_check_monitor #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int REG_ADDR_WIDTH = 5,
  parameter  int PC_WIDTH       = 32,
  parameter  int NUM_CHECKS     = 8,
  parameter  int HALT_STABLE    = 4,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int ERR_W          = $clog2(NUM_CHECKS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  wb_check_monitor_if.slave         wb,
  input  logic                      exp_we,
  input  logic [IDX_W-1:0]          exp_idx,
  input  logic [REG_ADDR_WIDTH-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0]     exp_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [ERR_W-1:0]          err_count,
  output logic                      mismatch,
  output logic [REG_ADDR_WIDTH-1:0] mm_addr,
  output logic [DATA_WIDTH-1:0]     mm_exp,
  output logic [DATA_WIDTH-1:0]     mm_got,
  output logic [15:0]               write_count
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;
  localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ST_W  = $clog2(HALT_STABLE + 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t                    state;
  logic [DATA_WIDTH-1:0]     shadow [DEPTH];
  logic                      tbl_valid [NUM_CHECKS];
  logic [REG_ADDR_WIDTH-1:0] tbl_addr  [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     tbl_data  [NUM_CHECKS];

  logic [CYC_W-1:0]          cycle_cnt;
  logic [ST_W-1:0]           stable_cnt;
  logic [PC_WIDTH-1:0]       prev_pc;
  logic                      prev_pc_valid;
  logic [IDX_W-1:0]          check_idx;

  logic                      idle_or_done;
  logic                      launch;
  logic                      wr_accept;
  logic                      tbl_wr;
  logic [ST_W-1:0]           stable_nxt;
  logic                      halt;
  logic                      budget_out;
  logic                      last_entry;
  logic [REG_ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]     cur_exp;
  logic [DATA_WIDTH-1:0]     cur_got;
  logic                      cur_fail;

  // Decode launch/halt/compare conditions for the current cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    stable_nxt = '0;
    cur_got    = '0;
    idle_or_done = (state == IDLE) || (state == DONE);
    launch       = idle_or_done && start;
    wr_accept    = wb.wb_en && (wb.wb_addr != '0);
    tbl_wr       = idle_or_done && exp_we && (int'(exp_idx) < NUM_CHECKS);
    if (prev_pc_valid && (wb.pc == prev_pc)) stable_nxt = stable_cnt + 1'b1;
    halt       = (stable_nxt == ST_W'(HALT_STABLE - 1));
    budget_out = (cycle_cnt == CYC_W'(TIMEOUT_CYCLES - 1));
    last_entry = (check_idx == IDX_W'(NUM_CHECKS - 1));
    cur_addr   = tbl_addr[check_idx];
    cur_exp    = tbl_data[check_idx];
    if (cur_addr != '0) cur_got = shadow[cur_addr];
    cur_fail   = tbl_valid[check_idx] && (cur_got != cur_exp);
  end

  // Shadow register file: cleared on launch, written only while RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shadow array is reset because a check may read registers the
    // program never wrote; those must compare against a known 0.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (launch) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (state == RUN && wr_accept) begin
      shadow[wb.wb_addr] <= wb.wb_data;
    end
  end

  // Expectation valid bits: reset clears the table, launch keeps it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) tbl_valid[i] <= 1'b0;
    end else if (tbl_wr) begin
      tbl_valid[exp_idx] <= 1'b1;
    end
  end

  // Expectation payload: only ever read behind its valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      tbl_addr[exp_idx] <= exp_addr;
      tbl_data[exp_idx] <= exp_data;
    end
  end

  // Control FSM with registered status and mismatch-detail outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      mismatch      <= 1'b0;
      mm_addr       <= '0;
      mm_exp        <= '0;
      mm_got        <= '0;
      write_count   <= '0;
      cycle_cnt     <= '0;
      stable_cnt    <= '0;
      prev_pc       <= '0;
      prev_pc_valid <= 1'b0;
      check_idx     <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            write_count   <= '0;
            cycle_cnt     <= '0;
            stable_cnt    <= '0;
            prev_pc_valid <= 1'b0;
            check_idx     <= '0;
          end
        end
        RUN: begin
          prev_pc       <= wb.pc;
          prev_pc_valid <= 1'b1;
          stable_cnt    <= stable_nxt;
          cycle_cnt     <= cycle_cnt + 1'b1;
          if (wr_accept && write_count != 16'hFFFF) write_count <= write_count + 1'b1;
          // Halt is tested first so it wins a same-cycle tie with the budget.
          if (halt) begin
            state     <= CHECK;
            check_idx <= '0;
          end else if (budget_out) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        CHECK: begin
          if (cur_fail) begin
            mismatch  <= 1'b1;
            mm_addr   <= cur_addr;
            mm_exp    <= cur_exp;
            mm_got    <= cur_got;
            err_count <= err_count + 1'b1;
          end
          check_idx <= check_idx + 1'b1;
          if (last_entry) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= !timeout && (err_count == '0) && !cur_fail;
            check_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_check_monitor.md
# wb_check_monitor

Parametrised self-checking writeback monitor for the RISC-V core benches.
- Snoops the register-file write port and keeps a shadow register file.
- Detects program halt, either a PC self-loop or a cycle-budget timeout.
- On halt, compares up to NUM_CHECKS loaded expectations against the shadow file, one per cycle, and reports pass/fail, an error count and per-mismatch detail.
- Replaces hand-written per-register checks and hierarchical peeks into the core's register file; it connects only to ports.

## Interface
- DATA_WIDTH, 32, register/writeback data width
- REG_ADDR_WIDTH, 5, register address width; shadow depth 2**REG_ADDR_WIDTH
- PC_WIDTH, 32, program counter width
- NUM_CHECKS, 8, expectation table entries (>=1)
- HALT_STABLE, 4, consecutive cycles of unchanged pc that declare halt (>=2)
- TIMEOUT_CYCLES, 1000, RUN-state cycle budget
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run (honoured in IDLE and DONE only)
- wb_en  in  1  register write strobe from writeback stage
- wb_addr  in  REG_ADDR_WIDTH  write address
- wb_data  in  DATA_WIDTH  write data
- pc  in  PC_WIDTH  fetch PC of the core
- exp_we  in  1  expectation table write (honoured in IDLE and DONE only)
- exp_idx  in  clog2(NUM_CHECKS)  table entry index
- exp_addr  in  REG_ADDR_WIDTH  register to check
- exp_data  in  DATA_WIDTH  expected value
- busy  out  1  high in RUN or CHECK
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 iff no timeout and err_count==0
- timeout  out  1  run ended by cycle budget
- err_count  out  clog2(NUM_CHECKS+1)  mismatches in the last check pass
- mismatch  out  1  one-cycle pulse per failing entry
- mm_addr  out  REG_ADDR_WIDTH  failing register, valid with mismatch
- mm_exp  out  DATA_WIDTH  expected value, valid with mismatch
- mm_got  out  DATA_WIDTH  shadow value, valid with mismatch
- write_count  out  16  accepted writes this run, saturating at 0xFFFF

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
  - IDLE/DONE, start=1 -> RUN. On entry: clear shadow file, write_count, cycle counter, stable counter, err_count and timeout. Expectation table is retained.
  - RUN -> CHECK when the stable counter reaches HALT_STABLE-1 (pc equal to the previous cycle's pc for HALT_STABLE-1 consecutive compares, i.e. HALT_STABLE equal samples).
  - RUN -> DONE with timeout=1 when the cycle counter reaches TIMEOUT_CYCLES-1. No checks run.
  - If halt and timeout occur in the same cycle, halt wins.
  - CHECK walks entries 0..NUM_CHECKS-1, one per cycle, then -> DONE.
- Shadow file:
  - Written in RUN only, when wb_en=1 and wb_addr!=0.
  - x0 always reads 0; writes to x0 are ignored and not counted.
  - Frozen in CHECK and DONE.
  - All entries reset to 0.
- Expectation table:
  - Each entry holds a valid bit, an address and data.
  - An exp_we write sets the entry's valid bit.
  - Writes arriving in RUN or CHECK are dropped.
  - Invalid entries are skipped: they take a cycle but produce no compare.
- Compare: entry valid and shadow[exp_addr] != exp_data gives mismatch=1 next cycle with mm_* set, and err_count increments. err_count cannot overflow because it is sized for NUM_CHECKS.
- Halt drain: HALT_STABLE must cover the core's pipeline depth, so in-flight writes land before CHECK. Writes that are still arriving in the halt-detect cycle are accepted.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including pass, done and mm_*.
  - Shadow file and table valid bits 0.
- start to busy: 1 cycle.
- wb write to shadow visible: next cycle.
- CHECK lasts exactly NUM_CHECKS cycles.
- mismatch lags its entry by 1 cycle; the last pulse may coincide with the first DONE cycle.
- done, pass, timeout and err_count hold in DONE until the next start or reset.
- Reset asserted mid-RUN or mid-CHECK returns to IDLE immediately and clears the table. The aborted run reports nothing.
- start held high across DONE re-launches exactly once per rising of state into DONE. The level is sampled only in IDLE/DONE.

## Test plan
- Branch/jump program:
  - Table: x1=10, x2=10, x3=55, x5=100, x6=0x20, x7=66, x8=200.
  - Core ends in a jal self-loop.
  - Expect: done, pass=1, err_count=0, write_count equal to the program's non-x0 writes.
- Same program with entry x3=56:
  - Expect exactly one mismatch pulse, with mm_addr=3, mm_exp=56, mm_got=55.
  - Expect err_count=1, pass=0.
- pc never stable, TIMEOUT_CYCLES=50: expect timeout=1, done at RUN cycle 50, no mismatch pulses, pass=0.
- wb writes to x0=0xDEAD and x4=7 in the same run; table x0=0, x4=7:
  - Expect pass=1.
  - Expect write_count=1.
- exp_we to x9=1 asserted during RUN is dropped. A second run with x9 loaded in DONE checks it.
- Assert rst_n=0 mid-CHECK:
  - Expect all outputs 0 asynchronously and state IDLE.
  - After a reload, the next run completes normally.
